axis_msg_framer: RTL and testbench

- Byte-write message collector sitting directly upstream of the RMII UDP transmit generator.
- Software or GPIO logic writes message bytes one at a time, then commits the message.
- The block replays the stored message as a single AXI-Stream frame:
  - 8-bit TDATA.
  - TLAST on the final byte.
  - TUSER carrying the payload byte count, which the transmitter uses to size the IPv4/UDP header and its FIFO check.

---
 rtl/eth_pkg.sv | 13 +
 rtl/msg_ram.sv | 30 +++
 rtl/axis_msg_framer.sv | 157 +++++++++++++++
 tb/tb_axis_msg_framer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet/UDP sizing constants and the message framer state type.
package eth_pkg;

    localparam int ETH_MIN_PAYLOAD = 18;
    localparam int UDP_MAX_PAYLOAD = 1472;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } framer_state_t;

endpackage

// File: rtl/msg_ram.sv
// Single-port byte RAM with a registered, enable-gated read (block RAM template).
module msg_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1472,
    parameter int AW     = 11
) (
    input  logic              CLK,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Read data holds while i_re is low, which is what keeps a stalled beat stable.
    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axis_msg_framer.sv
// Byte-write message collector that replays one committed message as an AXI-Stream frame.
// Optional short-frame zero padding is built when AXIS_MSG_FRAMER_PAD_EN is defined.
module axis_msg_framer
    import eth_pkg::*;
#(
    parameter int MAX_BYTES   = UDP_MAX_PAYLOAD,
    parameter int MIN_PAYLOAD = ETH_MIN_PAYLOAD,
    parameter int AW          = $clog2(MAX_BYTES + 1)
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    input  logic        wr_commit,
    output logic        wr_ready,
    output logic [7:0]  M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    output logic        M_AXIS_TLAST,
    input  logic        M_AXIS_TREADY,
    output logic [11:0] M_AXIS_TUSER,
    output logic        overflow,
    output logic        busy
);

    localparam logic [AW-1:0] MAX_CNT = AW'(MAX_BYTES);
    localparam logic [AW-1:0] ONE     = AW'(1);

    framer_state_t r_state;
    logic [AW-1:0] r_count;
    logic [AW-1:0] r_rptr;
    logic [AW-1:0] r_tlen;
    logic          r_overflow;

    logic          w_fill;
    logic          w_load;
    logic          w_send;
    logic          w_wr_acc;
    logic [AW-1:0] w_eff_len;
    logic          w_commit;
    logic [AW-1:0] w_tlen_nx;
    logic          w_hs;
    logic          w_last;
    logic [AW-1:0] w_rptr_nx;
    logic          w_rd_data_beat;
    logic          w_pad_beat;
    logic          w_ram_re;
    logic [AW-1:0] w_ram_addr;
    logic [7:0]    w_rdata;

    assign w_fill    = (r_state == FILL);
    assign w_load    = (r_state == LOAD);
    assign w_send    = (r_state == SEND);
    assign w_wr_acc  = w_fill && wr_valid && (r_count != MAX_CNT);
    assign w_eff_len = r_count + AW'(w_wr_acc);
    assign w_commit  = w_fill && wr_commit && (w_eff_len != '0);
    assign w_hs      = w_send && M_AXIS_TREADY;
    assign w_last    = (r_rptr == r_tlen - ONE);
    assign w_rptr_nx = r_rptr + ONE;

`ifdef AXIS_MSG_FRAMER_PAD_EN
    localparam logic [AW-1:0] MIN_CNT = AW'(MIN_PAYLOAD);

    // Stored length; beats beyond it are zero fill and never touch the RAM.
    logic [AW-1:0] r_dlen;

    always_ff @(posedge CLK) begin
        if (w_commit) begin
            r_dlen <= w_eff_len;
        end
    end

    assign w_tlen_nx      = (w_eff_len < MIN_CNT) ? MIN_CNT : w_eff_len;
    assign w_rd_data_beat = (w_rptr_nx < r_dlen);
    assign w_pad_beat     = (r_rptr >= r_dlen);
`else
    // MIN_PAYLOAD only shapes frames when padding is compiled in.
    if (MIN_PAYLOAD > MAX_BYTES) begin : g_min_payload_over_max
    end

    assign w_tlen_nx      = w_eff_len;
    assign w_rd_data_beat = 1'b1;
    assign w_pad_beat     = 1'b0;
`endif

    // Prefetch: each handshake reads the following byte so the next beat is ready with no bubble.
    assign w_ram_re   = w_load || (w_hs && !w_last && w_rd_data_beat);
    assign w_ram_addr = w_fill ? r_count : (w_load ? '0 : w_rptr_nx);

    msg_ram #(
        .DATA_W (8),
        .DEPTH  (MAX_BYTES),
        .AW     (AW)
    ) u_ram (
        .CLK     (CLK),
        .i_we    (w_wr_acc),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (wr_data),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            r_state    <= FILL;
            r_count    <= '0;
            r_rptr     <= '0;
            r_tlen     <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_commit) begin
                        r_state    <= LOAD;
                        r_count    <= w_eff_len;
                        r_tlen     <= w_tlen_nx;
                        r_rptr     <= '0;
                        r_overflow <= 1'b0;
                    end else begin
                        if (w_wr_acc) begin
                            r_count <= w_eff_len;
                        end
                        if (wr_valid && (r_count == MAX_CNT)) begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    r_state <= SEND;
                end
                SEND: begin
                    if (w_hs) begin
                        if (w_last) begin
                            r_state <= FILL;
                            r_count <= '0;
                            r_rptr  <= '0;
                            r_tlen  <= '0;
                        end else begin
                            r_rptr <= w_rptr_nx;
                        end
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

    assign wr_ready      = w_fill;
    assign busy          = !w_fill;
    assign overflow      = r_overflow;
    assign M_AXIS_TVALID = w_send;
    assign M_AXIS_TLAST  = w_send && w_last;
    assign M_AXIS_TUSER  = 12'(r_tlen);
    assign M_AXIS_TDATA  = (w_send && !w_pad_beat) ? w_rdata : 8'h00;

endmodule

// File: tb/tb_axis_msg_framer.sv
// Scoreboard bench for axis_msg_framer: a queue-based message model predicts every beat.
module tb_axis_msg_framer;

    localparam int MAXB = 1472;
    localparam int MINP = 18;

    typedef struct {
        logic [7:0]  d;
        logic        l;
        logic [11:0] u;
    } beat_t;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_commit;
    logic        wr_ready;
    logic [7:0]  M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TREADY;
    logic [11:0] M_AXIS_TUSER;
    logic        overflow;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    beat_t      exp_q[$];
    bit         m_ovf = 1'b0;

    int rdy_mode = 0;
    int pat_idx  = 0;
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    axis_msg_framer dut (
        .CLK           (CLK),
        .reset_n       (reset_n),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_commit     (wr_commit),
        .wr_ready      (wr_ready),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .M_AXIS_TUSER  (M_AXIS_TUSER),
        .overflow      (overflow),
        .busy          (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: the message is a byte queue capped at MAXB; a commit turns it into beats.
    function automatic void model_write(input logic [7:0] b);
        if (mq.size() < MAXB) mq.push_back(b);
        else m_ovf = 1'b1;
    endfunction

    function automatic int push_frame();
        int    len;
        int    t;
        beat_t bt;
        len = mq.size();
        t   = len;
`ifdef AXIS_MSG_FRAMER_PAD_EN
        if (t < MINP) t = MINP;
`endif
        for (int i = 0; i < t; i++) begin
            bt.d = (i < len) ? mq[i] : 8'h00;
            bt.l = (i == t - 1);
            bt.u = 12'(t);
            exp_q.push_back(bt);
        end
        mq.delete();
        m_ovf = 1'b0;
        return t;
    endfunction

    task automatic wr_byte(input logic [7:0] b);
        wr_valid  = 1'b1;
        wr_data   = b;
        wr_commit = 1'b0;
        @(posedge CLK);
        model_write(b);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic do_commit(input bit with_byte, input logic [7:0] b);
        bit took;
        int t;
        t         = 0;
        wr_valid  = with_byte;
        wr_data   = b;
        wr_commit = 1'b1;
        @(posedge CLK);
        if (with_byte) model_write(b);
        took = (mq.size() != 0);
        if (took) t = push_frame();
        #1;
        wr_valid  = 1'b0;
        wr_commit = 1'b0;
        if (took) begin
            @(negedge CLK);
            check("load_tuser", M_AXIS_TUSER, t);
            check("load_tvalid", M_AXIS_TVALID, 0);
            check("load_busy_ready", {busy, wr_ready}, 2'b10);
            check("load_overflow", overflow, 0);
            @(negedge CLK);
            check("first_tvalid", M_AXIS_TVALID, 1);
        end
    endtask

    // Waits for the frame to drain; pokes ignored writes/commits while the next edge is certainly busy.
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || wr_ready !== 1'b1) && n < 5000) begin
            if (wr_ready === 1'b0 && exp_q.size() >= 2 && $urandom_range(0, 3) == 0) begin
                wr_valid  = 1'($urandom);
                wr_commit = 1'($urandom);
                wr_data   = 8'($urandom);
            end
            @(posedge CLK);
            #1;
            wr_valid  = 1'b0;
            wr_commit = 1'b0;
            n++;
        end
        check(name, (n < 5000), 1);
    endtask

    // TREADY driver: 0 = always ready, 1 = fixed stall pattern from the first beat, 2 = random.
    initial begin
        M_AXIS_TREADY = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (rdy_mode)
                0: M_AXIS_TREADY = 1'b1;
                1: begin
                    if (pat_idx >= 7) M_AXIS_TREADY = 1'b1;
                    else if (M_AXIS_TVALID === 1'b1) begin
                        M_AXIS_TREADY = pat[pat_idx];
                        pat_idx++;
                    end
                end
                default: M_AXIS_TREADY = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    // Monitor: pops on every handshake, verifies stall stability and the return to FILL.
    initial begin
        bit         stall_pend;
        bit         after_last;
        logic [7:0] h_d;
        logic       h_l;
        logic [11:0] h_u;
        beat_t      e;
        stall_pend = 1'b0;
        after_last = 1'b0;
        forever begin
            @(negedge CLK);
            if (reset_n !== 1'b1) begin
                stall_pend = 1'b0;
                after_last = 1'b0;
            end else begin
                if (after_last) begin
                    check("after_last_ready", wr_ready, 1);
                    check("after_last_tvalid", M_AXIS_TVALID, 0);
                    check("after_last_tuser", M_AXIS_TUSER, 0);
                    after_last = 1'b0;
                end
                if (stall_pend) begin
                    check("stall_tvalid", M_AXIS_TVALID, 1);
                    check("stall_hold", {M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TUSER}, {h_d, h_l, h_u});
                end
                stall_pend = 1'b0;
                if (M_AXIS_TVALID === 1'b1) begin
                    if (M_AXIS_TREADY === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_beat", {M_AXIS_TDATA, M_AXIS_TLAST}, 0);
                            bad++;
                            $display("FAIL unexpected_beat: got TVALID handshake expected none");
                        end else begin
                            e = exp_q.pop_front();
                            check("beat_data", M_AXIS_TDATA, e.d);
                            check("beat_last", M_AXIS_TLAST, e.l);
                            check("beat_user", M_AXIS_TUSER, e.u);
                        end
                        if (M_AXIS_TLAST === 1'b1) after_last = 1'b1;
                    end else begin
                        stall_pend = 1'b1;
                        h_d = M_AXIS_TDATA;
                        h_l = M_AXIS_TLAST;
                        h_u = M_AXIS_TUSER;
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         len;
        bit         comb;
        logic [7:0] b;

        reset_n   = 1'b0;
        wr_valid  = 1'b0;
        wr_commit = 1'b0;
        wr_data   = 8'h00;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_tvalid", M_AXIS_TVALID, 0);
        check("rst_tlast", M_AXIS_TLAST, 0);
        check("rst_tuser", M_AXIS_TUSER, 0);
        check("rst_tdata", M_AXIS_TDATA, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_ready", wr_ready, 1);
        @(posedge CLK);
        #1;
        reset_n = 1'b1;
        @(negedge CLK);
        check("post_rst_ready", wr_ready, 1);

        // "Hi\r\n" with TREADY held high
        wr_byte(8'h48); wr_byte(8'h69); wr_byte(8'h0D); wr_byte(8'h0A);
        do_commit(1'b0, 8'h00);
        wait_idle("hi_idle");

        // Same frame through the 1,0,0,1,0,1,1 stall pattern
        pat_idx  = 0;
        rdy_mode = 1;
        wr_byte(8'h48); wr_byte(8'h69); wr_byte(8'h0D); wr_byte(8'h0A);
        do_commit(1'b0, 8'h00);
        wait_idle("stall_idle");
        rdy_mode = 0;

        // Overflow: three bytes beyond capacity are dropped
        for (int i = 0; i < MAXB + 3; i++) wr_byte(8'(i * 7 + 3));
        @(negedge CLK);
        check("overflow_set", overflow, 1);
        check("overflow_model", overflow, m_ovf);
        do_commit(1'b0, 8'h00);
        check("overflow_cleared", overflow, 0);
        wait_idle("overflow_idle");

        // Empty commit is ignored
        do_commit(1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("empty_tvalid", M_AXIS_TVALID, 0);
            check("empty_state", {wr_ready, busy}, 2'b10);
        end

        // Single byte written in the commit cycle
        do_commit(1'b1, 8'hA5);
        wait_idle("a5_idle");

        // Reset on the third beat of a 10-byte frame
        for (int i = 0; i < 10; i++) wr_byte(8'(8'h10 + i));
        do_commit(1'b0, 8'h00);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        reset_n = 1'b0;
        @(posedge CLK);
        #1;
        reset_n = 1'b1;
        exp_q.delete();
        mq.delete();
        m_ovf = 1'b0;
        check("abort_tvalid", M_AXIS_TVALID, 0);
        check("abort_tuser", M_AXIS_TUSER, 0);
        check("abort_ready", wr_ready, 1);
        wr_byte(8'hC3); wr_byte(8'h3C);
        do_commit(1'b0, 8'h00);
        wait_idle("post_abort_idle");

        // Randomised frames under random backpressure
        rdy_mode = 2;
        for (int f = 0; f < 16; f++) begin
            len  = (f % 4 == 0) ? $urandom_range(1, 3) : $urandom_range(1, 48);
            comb = 1'($urandom);
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                if (comb && i == len - 1) begin
                    do_commit(1'b1, b);
                end else begin
                    wr_byte(b);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge CLK);
                        #1;
                    end
                end
            end
            if (!comb) begin
                check("rand_pre_commit_ovf", overflow, m_ovf);
                do_commit(1'b0, 8'h00);
            end
            wait_idle("rand_idle");
        end
        rdy_mode = 0;

        repeat (3) @(negedge CLK);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
